// File: rtl/quad_decoder_pkg.sv
// quad_decoder_pkg
//   Shared types and the Gray-code step decoder used by every encoder
//   channel of quad_decoder.
//   - qstate_t    : 2-bit encoder state, packed as {a,b}
//   - step_t      : classification of one accepted state change
//   - decode_step : pure function mapping (prev, next) to a step_t
package quad_decoder_pkg;

  typedef logic [1:0] qstate_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_CW   = 2'd1,
    STEP_CCW  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // Position of a state along the clockwise cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_idx(input qstate_t s);
    logic [1:0] idx;
    case (s)
      2'b00:   idx = 2'd0;
      2'b10:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // The modulo-4 distance along the cycle classifies the step:
  // +1 is clockwise, -1 (3) counter-clockwise, 2 is a two-bit jump.
  function automatic step_t decode_step(input qstate_t prev, input qstate_t next);
    logic [1:0] diff;
    step_t      step;
    diff = gray_idx(next) - gray_idx(prev);
    case (diff)
      2'd1:    step = STEP_CW;
      2'd3:    step = STEP_CCW;
      2'd2:    step = STEP_ERR;
      default: step = STEP_NONE;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/quad_channel.sv
// quad_channel
//   One quadrature encoder channel: 2-flop synchroniser on {a,b}, optional
//   stability filter, Gray-code step decode, wrapping signed position counter.
//   Optional feature: define QUAD_DECODER_FILTER_EN to require the
//   synchronised pair to be stable for FILT_LEN cycles before acceptance.
//   Ports:
//     clk, rst      - clock, asynchronous active-high reset
//     a, b          - raw encoder pins (asynchronous)
//     clr           - synchronous clear of position and err_sticky
//     cw, ccw, err  - registered single-cycle step / illegal-jump pulses
//     err_sticky    - set by err, held until clr or rst
//     position      - signed wrapping position count
module quad_channel
  import quad_decoder_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a,
  input  logic                    b,
  input  logic                    clr,
  output logic                    cw,
  output logic                    ccw,
  output logic                    err,
  output logic                    err_sticky,
  output logic signed [CNT_W-1:0] position
);

  if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_bad_filt_len
    $error("quad_channel: FILT_LEN must be in 1..255");
  end

  localparam logic signed [CNT_W-1:0] POS_ONE = CNT_W'(1);

  // Two's complement step of the position counter; wraps naturally.
  function automatic logic signed [CNT_W-1:0] wrap_step(
    input logic signed [CNT_W-1:0] v,
    input logic                    up
  );
    return up ? (v + POS_ONE) : (v - POS_ONE);
  endfunction

  // ---- Stage p0/p1: synchroniser; vld marks samples taken after reset ----
  qstate_t ab_p0_q, ab_p0_d;
  qstate_t s_p1_q,  s_p1_d;
  logic    vld_p0_q, vld_p0_d;
  logic    vld_p1_q, vld_p1_d;

  always_comb begin
    ab_p0_d  = {a, b};
    s_p1_d   = ab_p0_q;
    vld_p0_d = 1'b1;
    vld_p1_d = vld_p0_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ab_p0_q  <= 2'b00;
      s_p1_q   <= 2'b00;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      ab_p0_q  <= ab_p0_d;
      s_p1_q   <= s_p1_d;
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  // ---- Acceptance: which synchronised sample is offered to the decoder ----
  logic    accept;
  qstate_t sample;

`ifdef QUAD_DECODER_FILTER_EN
  localparam int                FCNT_W   = $clog2(FILT_LEN + 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILT_LEN - 1);

  qstate_t           cand_q, cand_d;
  logic              cand_vld_q, cand_vld_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // Any change of s reloads the candidate and restarts the window. The
  // candidate is offered on the FILT_LEN-th stable cycle, so the filter adds
  // exactly FILT_LEN cycles; re-offering it later is harmless (n == q).
  always_comb begin
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    fcnt_d     = fcnt_q;
    if (vld_p1_q) begin
      if (!cand_vld_q || (s_p1_q != cand_q)) begin
        cand_d     = s_p1_q;
        cand_vld_d = 1'b1;
        fcnt_d     = '0;
      end else if (fcnt_q != FCNT_MAX) begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    accept = cand_vld_q && (s_p1_q == cand_q) && (fcnt_q == FCNT_MAX);
    sample = cand_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q     <= 2'b00;
      cand_vld_q <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      fcnt_q     <= fcnt_d;
    end
  end
`else
  always_comb begin
    accept = vld_p1_q;
    sample = s_p1_q;
  end
`endif

  // ---- Stage p2: decode, count, registered pulses ----
  qstate_t                 q_q, q_d;
  logic                    primed_q, primed_d;
  logic signed [CNT_W-1:0] pos_q, pos_d;
  logic                    cw_q, cw_d;
  logic                    ccw_q, ccw_d;
  logic                    err_q, err_d;
  logic                    sticky_q, sticky_d;
  step_t                   step;

  always_comb begin
    step     = decode_step(q_q, sample);
    q_d      = q_q;
    primed_d = primed_q;
    pos_d    = pos_q;
    cw_d     = 1'b0;
    ccw_d    = 1'b0;
    err_d    = 1'b0;
    sticky_d = sticky_q;

    if (accept) begin
      // q always follows the accepted sample, which also resyncs after
      // an illegal jump.
      q_d = sample;
      if (!primed_q) begin
        primed_d = 1'b1;
      end else begin
        case (step)
          STEP_CW: begin
            cw_d  = 1'b1;
            pos_d = wrap_step(pos_q, 1'b1);
          end
          STEP_CCW: begin
            ccw_d = 1'b1;
            pos_d = wrap_step(pos_q, 1'b0);
          end
          STEP_ERR: begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
          end
          default: ;
        endcase
      end
    end

    // Clear overrides any same-cycle count or sticky set; pulses still issue.
    if (clr) begin
      pos_d    = '0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q      <= 2'b00;
      primed_q <= 1'b0;
      pos_q    <= '0;
      cw_q     <= 1'b0;
      ccw_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      primed_q <= primed_d;
      pos_q    <= pos_d;
      cw_q     <= cw_d;
      ccw_q    <= ccw_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign cw         = cw_q;
  assign ccw        = ccw_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign position   = pos_q;

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder
//   Multi-channel quadrature decoder: NUM_CH independent quad_channel
//   instances with packed outputs.
//   Optional feature: define QUAD_DECODER_FILTER_EN to enable the per-channel
//   FILT_LEN-cycle glitch filter (FILT_LEN is ignored otherwise).
//   Ports:
//     clk, rst       - clock, asynchronous active-high reset
//     a, b           - raw encoder pins, one bit per channel
//     clr            - per-channel synchronous clear of position/err_sticky
//     cw, ccw, err   - per-channel single-cycle pulses
//     err_sticky     - per-channel sticky illegal-jump flag
//     position       - packed signed counters, channel i at [i*CNT_W +: CNT_W]
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         a,
  input  logic [NUM_CH-1:0]         b,
  input  logic [NUM_CH-1:0]         clr,
  output logic [NUM_CH-1:0]         cw,
  output logic [NUM_CH-1:0]         ccw,
  output logic [NUM_CH-1:0]         err,
  output logic [NUM_CH-1:0]         err_sticky,
  output logic [NUM_CH*CNT_W-1:0]   position
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    quad_channel #(
      .CNT_W    (CNT_W),
      .FILT_LEN (FILT_LEN)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .a          (a[i]),
      .b          (b[i]),
      .clr        (clr[i]),
      .cw         (cw[i]),
      .ccw        (ccw[i]),
      .err        (err[i]),
      .err_sticky (err_sticky[i]),
      .position   (position[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder
//   Directed bench for quad_decoder: a 2-channel, 16-bit instance for
//   stepping, illegal jumps and clear, plus a 1-channel, 4-bit instance for
//   counter wrap. Expected latency follows QUAD_DECODER_FILTER_EN.
module tb_quad_decoder;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 16;
  localparam int FILT_LEN = 4;
  localparam int HOLD     = 12;
`ifdef QUAD_DECODER_FILTER_EN
  localparam int LAT = 3 + FILT_LEN;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NUM_CH-1:0]       a, b, clr;
  logic [NUM_CH-1:0]       cw, ccw, err, err_sticky;
  logic [NUM_CH*CNT_W-1:0] position;

  logic       a1, b1, clr1;
  logic       cw1, ccw1, err1, err_sticky1;
  logic [3:0] position1;

  quad_decoder #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
    .cw(cw), .ccw(ccw), .err(err), .err_sticky(err_sticky), .position(position)
  );

  quad_decoder #(.NUM_CH(1), .CNT_W(4), .FILT_LEN(FILT_LEN)) dut_w4 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .clr(clr1),
    .cw(cw1), .ccw(ccw1), .err(err1), .err_sticky(err_sticky1), .position(position1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse tallies, sampled on the falling edge.
  int cw_cnt[NUM_CH]  = '{default: 0};
  int ccw_cnt[NUM_CH] = '{default: 0};
  int err_cnt[NUM_CH] = '{default: 0};

  always @(negedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cw_cnt[ch]  += int'(cw[ch]);
      ccw_cnt[ch] += int'(ccw[ch]);
      err_cnt[ch] += int'(err[ch]);
    end
  end

  function automatic logic [CNT_W-1:0] pos_of(input int ch);
    return position[ch*CNT_W +: CNT_W];
  endfunction

  task automatic set_pins(input int ch, input logic [1:0] ab);
    a[ch] = ab[1];
    b[ch] = ab[0];
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new {a,b} state and hold it HOLD cycles; lat is the number of
  // rising edges until the first pulse on that channel (-1 if none).
  task automatic step_to(input int ch, input logic [1:0] ab, output int lat);
    set_pins(ch, ab);
    lat = -1;
    for (int i = 1; i <= HOLD; i++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && (cw[ch] | ccw[ch] | err[ch])) lat = i;
    end
  endtask

  logic [1:0] cw_seq[4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  initial begin
    int lat, first_lat;
    int c0, cc0, e0, e1, cc1;

    a = 2'b11; b = 2'b11; clr = 2'b00;
    a1 = 1'b0; b1 = 1'b0; clr1 = 1'b0;
    rst = 1'b1;
    wait_cycles(3);

    // Reset state
    check_eq("rst_position", position, '0);
    check_eq("rst_pulses", {cw, ccw, err}, '0);
    check_eq("rst_sticky", err_sticky, '0);

    // Release with pins held at 11: first sample only primes
    rst = 1'b0;
    wait_cycles(10);
    check_eq("prime_no_pulse", cw_cnt[0] + ccw_cnt[0] + err_cnt[0] + cw_cnt[1] + ccw_cnt[1] + err_cnt[1], 0);
    check_eq("prime_position", position, '0);

    // Re-reset mid-operation with pins moved to 00: still no error after release
    a = 2'b00; b = 2'b00;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(10);
    check_eq("rereset_no_err", err_cnt[0] + err_cnt[1], 0);

    // Eight clockwise steps on channel 0
    c0 = cw_cnt[0]; cc0 = ccw_cnt[0];
    first_lat = -1;
    for (int i = 0; i < 8; i++) begin
      step_to(0, cw_seq[i % 4], lat);
      if (i == 0) first_lat = lat;
    end
    check_eq("cw_latency", first_lat, LAT);
    check_eq("cw_count", cw_cnt[0] - c0, 8);
    check_eq("cw_no_ccw", ccw_cnt[0] - cc0, 0);
    check_eq("cw_position", pos_of(0), 16'd8);
    check_eq("ch1_idle_position", pos_of(1), 16'd0);

    // Illegal jump 00 -> 11
    e0 = err_cnt[0];
    step_to(0, 2'b11, lat);
    check_eq("err_latency", lat, LAT);
    check_eq("err_count", err_cnt[0] - e0, 1);
    check_eq("err_sticky_set", err_sticky[0], 1);
    check_eq("err_position", pos_of(0), 16'd8);

    // Legal step 11 -> 01 after the resync counts normally
    step_to(0, 2'b01, lat);
    check_eq("resync_position", pos_of(0), 16'd9);
    check_eq("sticky_held", err_sticky[0], 1);

    // Clear
    clr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    check_eq("clr_position", pos_of(0), 16'd0);
    check_eq("clr_sticky", err_sticky[0], 0);

    step_to(0, 2'b00, lat);
    check_eq("pre_clr_step_position", pos_of(0), 16'd1);

    // Channel 0 CW step coincides with clr; channel 1 steps CCW alongside
    cc1 = ccw_cnt[1];
    set_pins(0, 2'b10);
    set_pins(1, 2'b01);
    repeat (LAT - 1) @(posedge clk);
    #1;
    clr[0] = 1'b1;
    @(posedge clk);
    #1;
    clr[0] = 1'b0;
    check_eq("clr_step_cw", cw[0], 1);
    check_eq("clr_step_position", pos_of(0), 16'd0);
    check_eq("ch1_ccw_pulse", ccw[1], 1);
    check_eq("ch1_position", pos_of(1), 16'hFFFF);
    wait_cycles(HOLD);
    check_eq("clr_step_hold", pos_of(0), 16'd0);
    check_eq("ch1_ccw_count", ccw_cnt[1] - cc1, 1);

    // 4-bit counter wrap: 7 CW steps, then CW to -8, then CCW back to 7
    for (int i = 0; i < 7; i++) begin
      {a1, b1} = cw_seq[i % 4];
      wait_cycles(HOLD);
    end
    check_eq("wrap_pre", position1, 4'h7);
    {a1, b1} = 2'b00;
    wait_cycles(HOLD);
    check_eq("wrap_max_to_min", position1, 4'h8);
    {a1, b1} = 2'b01;
    wait_cycles(HOLD);
    check_eq("wrap_min_to_max", position1, 4'h7);
    check_eq("wrap_no_err", err_sticky1, 0);

`ifdef QUAD_DECODER_FILTER_EN
    // Two-cycle glitch on A of channel 1 (01 -> 11 -> 01) is discarded
    c0 = cw_cnt[1] + ccw_cnt[1];
    e1 = err_cnt[1];
    set_pins(1, 2'b11);
    wait_cycles(2);
    set_pins(1, 2'b01);
    wait_cycles(HOLD);
    check_eq("glitch_steps", cw_cnt[1] + ccw_cnt[1] - c0, 0);
    check_eq("glitch_err", err_cnt[1] - e1, 0);
    check_eq("glitch_position", pos_of(1), 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Multi-channel quadrature decoder for the arm's joint rotary encoders. Each of `NUM_CH` channels synchronises its raw A/B pins, optionally glitch-filters them, decodes every valid Gray-code step into registered single-cycle `cw`/`ccw` pulses and keeps a wrapping signed position count. Illegal two-bit jumps are flagged, not counted. Sits between the encoder pins and the joint position/motor control logic.

## Interface
- `NUM_CH`, 4, number of independent encoder channels (1..16)
- `CNT_W`, 16, width of each signed position counter (2..32)
- `FILT_LEN`, 4, cycles a synchronised A/B pair must be stable before acceptance (filter build only, 1..255)

- `clk` in 1 — single system clock, all logic on rising edge
- `rst` in 1 — asynchronous, active-high reset
- `a` in NUM_CH — raw encoder A per channel, asynchronous to `clk`
- `b` in NUM_CH — raw encoder B per channel, asynchronous to `clk`
- `clr` in NUM_CH — synchronous per-channel clear of position and sticky error
- `cw` out NUM_CH — one-cycle pulse per accepted clockwise step
- `ccw` out NUM_CH — one-cycle pulse per accepted counter-clockwise step
- `err` out NUM_CH — one-cycle pulse per illegal two-bit transition
- `err_sticky` out NUM_CH — set by `err`, held until `clr` or `rst`
- `position` out NUM_CH*CNT_W — packed signed counters, channel i at bits [i*CNT_W +: CNT_W]

## Operation
- Per channel: 2-flop synchroniser on {a,b} → sampled pair `s`; accepted state `q` (2 bits) plus `primed` flag.
- Reset: sync flops, `q`, `primed`, `position`, `cw`, `ccw`, `err`, `err_sticky` all 0.
- First accepted sample after reset (`primed`=0): load `q`, set `primed`; no pulse, no count, no error.
- Accepted sample `n` ≠ `q` (q→n as {a,b}):
  - CW: 00→10, 10→11, 11→01, 01→00 → `cw`=1, `position`+1.
  - CCW: 00→01, 01→11, 11→10, 10→00 → `ccw`=1, `position`−1.
  - Illegal: 00↔11, 01↔10 → `err`=1, `err_sticky`=1, position unchanged; `q` still loads `n` (resync).
- `n` = `q`: no action; all pulses 0.
- `cw`, `ccw`, `err` mutually exclusive per channel.
- Arithmetic: two's complement, wraps modulo 2^CNT_W (max+1 → min, min−1 → max), no saturation, no overflow flag.
- `clr` asserted: `position`←0, `err_sticky`←0 that cycle; step pulses still issue, but clear wins over same-cycle count; an `err` in the same cycle still pulses `err` but `err_sticky` ends 0.
- Channels fully independent; no shared state.

## Timing
- Unfiltered: pin edge meeting setup before edge k → `cw`/`ccw`/`err` high in cycle after edge k+2, `position` updated at same edge (3-cycle latency).
- Filtered: add FILT_LEN cycles (latency 3+FILT_LEN); any change of `s` during the window restarts it.
- Pulses exactly one cycle; max step rate one per cycle unfiltered, one per FILT_LEN+1 cycles filtered.
- `rst` asserted mid-operation: all state cleared immediately; `primed`=0 on release, so first post-reset sample never counts.

## Configuration
- `QUAD_DECODER_FILTER_EN` defined: per-channel stability counter ($clog2(FILT_LEN+1) bits) gates acceptance of `s` into `q`; pulses shorter than FILT_LEN cycles are discarded.
- Undefined: `s` accepted every cycle; `FILT_LEN` ignored; no counter logic instantiated.

## Structure
- Package `quad_decoder_pkg`: 2-bit `qstate_t`, step enum {STEP_NONE, STEP_CW, STEP_CCW, STEP_ERR}, pure function `decode_step(prev, next)` returning step enum.
- Sub-module `quad_channel`: one channel (sync, optional filter, decode, counter); top generates NUM_CH instances and packs outputs.

## Test plan
- Reset, hold a=b=1 then release → no pulse, `err`=0, `position`=0 after 10 cycles.
- 8 CW steps (00→10→11→01→00 ×2), 8 cycles per state → 8 `cw` pulses, `position`=8, latency 3 (filter off).
- CNT_W=4, position=7, one CW step → `position`=−8; one CCW → 7.
- Jump 00→11 → single `err` pulse, `err_sticky`=1, `position` unchanged; next legal step from 11 counts normally; `clr` → sticky 0.
- Filter on, FILT_LEN=4: 2-cycle glitch on A → nothing; 5-cycle stable change → `cw` at latency 7.
- CW step and `clr` same cycle on channel 0 while channel 1 steps CCW → ch0 `cw`=1, `position`=0; ch1 decrements, unaffected.
